// File: rtl/mem_stage_pkg.sv
// Shared bus widths, execute-to-memory field offsets and the latched
// instruction record for the memory stage.
package mem_stage_pkg;

  localparam int ES_TO_MS_WD = 183;
  localparam int MS_TO_WS_WD = 71;
  localparam int FWD_WD      = 39;

  localparam int ES_SIGN_EXT  = 174;
  localparam int ES_STORE_OP  = 138;
  localparam int ES_EXCP      = 77;
  localparam int ES_MEM_SIZE  = 75;
  localparam int ES_LOAD_OP   = 70;
  localparam int ES_GR_WE     = 69;
  localparam int ES_DEST      = 64;
  localparam int ES_RESULT    = 32;
  localparam int ES_PC        = 0;

  typedef struct packed {
    logic        sign_ext;
    logic        store_op;
    logic        excp;
    logic [1:0]  mem_size;
    logic        load_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] exe_result;
    logic [31:0] pc;
  } ms_inst_t;

  function automatic logic needs_dcache(input ms_inst_t inst);
    return (inst.load_op | inst.store_op) & ~inst.excp;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/halfword of a load response and sign- or
// zero-extends it to 32 bits.
module mem_stage_load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  mem_size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'b00: byte_sel = rdata[7:0];
      2'b01: byte_sel = rdata[15:8];
      2'b10: byte_sel = rdata[23:16];
      2'b11: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    result = rdata;
    if (mem_size[0]) begin
      result = {{24{sign_ext & byte_sel[7]}}, byte_sel};
    end else if (mem_size[1]) begin
      result = {{16{sign_ext & half_sel[15]}}, half_sel};
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, waits for the dcache
// response, aligns load data and tracks a killed access until it drains.
//
// state     | meaning
// EMPTY     | no valid instruction
// WAIT      | valid instruction, dcache access outstanding
// DONE      | valid instruction, result ready
// CANCEL    | no valid instruction, killed access still outstanding
module mem_stage #(
  parameter int ES_TO_MS_WD = mem_stage_pkg::ES_TO_MS_WD,
  parameter int MS_TO_WS_WD = mem_stage_pkg::MS_TO_WS_WD,
  parameter int FWD_WD      = mem_stage_pkg::FWD_WD
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   es_to_ms_valid,
  input  logic [ES_TO_MS_WD-1:0] es_to_ms_bus,
  output logic                   ms_allowin,
  input  logic                   ws_allowin,
  output logic                   ms_to_ws_valid,
  output logic [MS_TO_WS_WD-1:0] ms_to_ws_bus,
  output logic [FWD_WD-1:0]      ms_to_ds_forward_bus,
  output logic                   ms_flush,
  input  logic                   data_data_ok,
  input  logic [31:0]            data_rdata,
  input  logic                   excp_flush,
  input  logic                   ertn_flush,
  input  logic                   refetch_flush,
  input  logic                   icacop_flush,
  input  logic                   idle_flush
);

  import mem_stage_pkg::*;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_WAIT,
    ST_DONE,
    ST_CANCEL
  } state_e;

  state_e      state_q, state_d;
  ms_inst_t    inst_q, inst_d;
  ms_inst_t    es_inst;
  logic [31:0] resp_buf_q, resp_buf_d;
  logic        resp_buf_valid_q, resp_buf_valid_d;

  logic        flush;
  logic        ms_valid;
  logic        ready_go;
  logic        accept;
  logic        leave;
  logic        es_mem_req;
  logic [31:0] rdata_sel;
  logic [31:0] load_result;
  logic [31:0] final_result;
  logic        unused_es_bits;

  assign es_inst.sign_ext   = es_to_ms_bus[ES_SIGN_EXT];
  assign es_inst.store_op   = es_to_ms_bus[ES_STORE_OP];
  assign es_inst.excp       = es_to_ms_bus[ES_EXCP];
  assign es_inst.mem_size   = es_to_ms_bus[ES_MEM_SIZE +: 2];
  assign es_inst.load_op    = es_to_ms_bus[ES_LOAD_OP];
  assign es_inst.gr_we      = es_to_ms_bus[ES_GR_WE];
  assign es_inst.dest       = es_to_ms_bus[ES_DEST +: 5];
  assign es_inst.exe_result = es_to_ms_bus[ES_RESULT +: 32];
  assign es_inst.pc         = es_to_ms_bus[ES_PC +: 32];

  assign unused_es_bits = ^{es_to_ms_bus[ES_TO_MS_WD-1:ES_SIGN_EXT+1],
                            es_to_ms_bus[ES_SIGN_EXT-1:ES_STORE_OP+1],
                            es_to_ms_bus[ES_STORE_OP-1:ES_EXCP+1],
                            es_to_ms_bus[ES_MEM_SIZE-1:ES_LOAD_OP+1]};

  assign flush      = excp_flush | ertn_flush | refetch_flush | icacop_flush | idle_flush;
  assign ms_valid   = (state_q == ST_WAIT) || (state_q == ST_DONE);
  assign ready_go   = (state_q == ST_DONE) || ((state_q == ST_WAIT) && data_data_ok);
  assign ms_allowin = (state_q != ST_CANCEL) && (!ms_valid || (ready_go && ws_allowin));
  assign accept     = es_to_ms_valid && ms_allowin && !flush;
  assign leave      = ms_valid && ready_go && ws_allowin;
  assign es_mem_req = needs_dcache(es_inst);

  always_comb begin
    state_d          = state_q;
    inst_d           = inst_q;
    resp_buf_d       = resp_buf_q;
    resp_buf_valid_d = resp_buf_valid_q;

    case (state_q)
      ST_EMPTY, ST_DONE: begin
        if (flush) begin
          state_d = ST_EMPTY;
        end else if (accept) begin
          state_d = es_mem_req ? ST_WAIT : ST_DONE;
        end else if ((state_q == ST_DONE) && ws_allowin) begin
          state_d = ST_EMPTY;
        end
      end
      ST_WAIT: begin
        // A flush must not leave the in-flight response unclaimed.
        if (flush) begin
          state_d = data_data_ok ? ST_EMPTY : ST_CANCEL;
        end else if (data_data_ok) begin
          if (!ws_allowin) begin
            state_d = ST_DONE;
          end else if (accept) begin
            state_d = es_mem_req ? ST_WAIT : ST_DONE;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      ST_CANCEL: begin
        if (data_data_ok) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (accept) begin
      inst_d = es_inst;
    end

    if ((state_q == ST_WAIT) && data_data_ok) begin
      resp_buf_d       = data_rdata;
      resp_buf_valid_d = 1'b1;
    end
    if (flush || leave) begin
      resp_buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_EMPTY;
      inst_q           <= '0;
      resp_buf_q       <= '0;
      resp_buf_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      inst_q           <= inst_d;
      resp_buf_q       <= resp_buf_d;
      resp_buf_valid_q <= resp_buf_valid_d;
    end
  end

  assign rdata_sel = resp_buf_valid_q ? resp_buf_q : data_rdata;

  mem_stage_load_align u_load_align (
    .rdata    (rdata_sel),
    .addr     (inst_q.exe_result[1:0]),
    .mem_size (inst_q.mem_size),
    .sign_ext (inst_q.sign_ext),
    .result   (load_result)
  );

  assign final_result = (inst_q.load_op && !inst_q.excp) ? load_result : inst_q.exe_result;

  assign ms_to_ws_valid = ms_valid && ready_go && !flush;
  assign ms_flush       = ms_valid && inst_q.excp;

  assign ms_to_ws_bus = {inst_q.excp, inst_q.gr_we, inst_q.dest, final_result, inst_q.pc};

  assign ms_to_ds_forward_bus = {ms_valid && inst_q.load_op && !ready_go,
                                 ms_valid && inst_q.gr_we && (inst_q.dest != 5'd0),
                                 inst_q.dest,
                                 final_result};

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage and upstream of writeback.
- Accepts the execute-to-memory bus, waits for the data cache `data_ok` on loads and stores, then aligns and extends load data.
- Forwards results to decode and presents the writeback bus.
- Tracks a single outstanding dcache access so that a flush never orphans a response.

Parameters:
- ES_TO_MS_WD, 183, width of the incoming execute-to-memory bus.
- MS_TO_WS_WD, 71, width of the outgoing memory-to-writeback bus.
- FWD_WD, 39, width of the memory-to-decode forward bus.

Ports:
- clk  in  1  clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- es_to_ms_valid  in  1  execute stage has an instruction.
- es_to_ms_bus  in  ES_TO_MS_WD  fields used: [174] sign_ext, [138] store_op, [77] excp, [76:75] mem_size, [70] load_op, [69] gr_we, [68:64] dest, [63:32] exe_result, [31:0] pc.
- ms_allowin  out  1  stage can accept.
- ws_allowin  in  1  writeback can accept.
- ms_to_ws_valid  out  1  result valid to writeback.
- ms_to_ws_bus  out  MS_TO_WS_WD  [70] excp, [69] gr_we, [68:64] dest, [63:32] final_result, [31:0] pc.
- ms_to_ds_forward_bus  out  FWD_WD  [38] dep_need_stall, [37] forward_enable, [36:32] dest, [31:0] final_result.
- ms_flush  out  1  ms_valid & excp.
- data_data_ok  in  1  dcache response strobe for an accepted access.
- data_rdata  in  32  dcache read data, valid with data_data_ok.
- excp_flush, ertn_flush, refetch_flush, icacop_flush, idle_flush  in  1 each  pipeline flush sources; flush = OR of all five.

Behaviour:
- Reset values: ms_valid=0, state=EMPTY, resp_buf_valid=0, bus register=0. Consequently ms_allowin=1, ms_to_ws_valid=0, ms_flush=0, forward bus all 0.
- Access tag: mem_req = (load_op | store_op) & ~excp from the incoming bus. Execute only issues to dcache when ms_allowin=1, so acceptance implies at most one outstanding access.
- States:
  - EMPTY: no valid instruction.
  - WAIT: valid instruction, access outstanding.
  - DONE: valid instruction, ready_go=1.
  - CANCEL: no valid instruction, killed access still outstanding.
- Transitions from EMPTY/DONE, on es_to_ms_valid & ms_allowin & ~flush:
  - mem_req=1 → WAIT.
  - mem_req=0 → DONE.
  - Otherwise: DONE with ws_allowin → EMPTY; DONE without ws_allowin stays DONE.
- WAIT on data_data_ok: latch data_rdata into resp_buf and set resp_buf_valid.
  - ws_allowin=1 → pass through in the same cycle (ready_go combinationally true).
  - ws_allowin=0 → DONE.
- Earliest data_data_ok is the first cycle the instruction is held in this stage; latency is unbounded.
- Flush in WAIT with no data_data_ok in that cycle → CANCEL, ms_valid=0.
- Flush and data_data_ok in the same cycle → EMPTY; the response is consumed and discarded.
- CANCEL: ms_allowin=0; discard data_data_ok, then go to EMPTY.
- Flush in any other state → EMPTY. A flush has priority over a new accept in the same cycle.
- ms_allowin = (state != CANCEL) & (~ms_valid | ready_go & ws_allowin).
- ms_to_ws_valid = ms_valid & ready_go & ~flush.
- Load alignment, with addr[1:0] = exe_result[1:0] and rdata = resp_buf_valid ? resp_buf : data_rdata:
  - mem_size[0] (byte): byte selected by addr[1:0].
  - mem_size[1] (halfword): addr[1] selects the high or low half.
  - mem_size=00 (word): rdata unchanged.
  - Byte and halfword results are sign-extended when sign_ext=1, zero-extended otherwise.
- final_result:
  - load_op & ~excp → aligned data.
  - otherwise → exe_result. Stores pass exe_result.
- Forward bus:
  - forward_enable = ms_valid & gr_we & (dest != 0).
  - dep_need_stall = ms_valid & load_op & ~ready_go.
- resp_buf_valid clears when the instruction leaves the stage or on flush.

Decomposition:
- Shared header gets bus widths (ES_TO_MS_WD, MS_TO_WS_WD, FWD_WD) and bus field offsets, alongside the existing bus-width macros.
- State encodings are local.
- One sub-module: load_align, purely combinational. Inputs: rdata, addr[1:0], mem_size, sign_ext. Output: 32-bit result.

Test Plan:
- ld.b: addr low bits 2'b11, rdata=0x80FF_1234, sign_ext=1, data_ok 3 cycles after entry → final_result=0xFFFF_FF80. ms_allowin=0 while waiting; dep_need_stall=1 until data_ok.
- ld.hu: addr 0x...2, rdata=0x8001_7FFF, sign_ext=0 → 0x0000_8001. ld.w → 0x8001_7FFF.
- Load data_ok while ws_allowin=0 for 4 cycles, with data_rdata changing afterwards → buffered 0x1234_5678 delivered once ws_allowin=1; ms_to_ws_valid asserted exactly one cycle at handoff.
- excp_flush 1 cycle after load entry, data_ok 2 cycles later → CANCEL, ms_allowin=0 until that data_ok, no ms_to_ws_valid, EMPTY next cycle.
- Flush and data_ok in the same cycle → EMPTY immediately, ms_allowin=1 next cycle, nothing delivered.
- ALU instruction with dest=0, gr_we=1 → forward_enable=0, passes in 1 cycle.
- Asynchronous reset asserted mid-WAIT → outputs at reset values without waiting for a clock edge.
